// File: rtl/ysyx_22041211_trap_ctrl.sv
// Trap/mret sequencer: writes mepc/mcause on a trap, reads mtvec/mepc and pulses a PC redirect.
// Optional mstatus MIE/MPIE/MPP update is enabled by defining YSYX_22041211_TRAP_MSTATUS_EN.
module ysyx_22041211_trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic                  mret_req,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [11:0]           ex_csr_addr,
  input  logic [DATA_WIDTH-1:0] ex_csr_wdata,
  input  logic                  ex_csr_we,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_we,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    R_MTVEC   = 3'd4,
    R_MEPC    = 3'd5,
    REDIRECT  = 3'd6
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
  logic                  mret_q, mret_d;
  logic [DATA_WIDTH-1:0] mstatus_next;

  // Trap stacks MIE into MPIE; mret restores MIE from MPIE. Both force MPP to machine mode.
  always_comb begin
    mstatus_next          = csr_rdata;
    if (mret_q) begin
      mstatus_next[3]     = csr_rdata[7];
      mstatus_next[7]     = 1'b1;
    end else begin
      mstatus_next[7]     = csr_rdata[3];
      mstatus_next[3]     = 1'b0;
    end
    mstatus_next[12:11]   = 2'b11;
  end
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    redirect_pc_d  = redirect_pc_q;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
    mret_d         = mret_q;
`endif
    csr_addr       = '0;
    csr_wdata      = '0;
    csr_we         = 1'b0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        csr_addr  = ex_csr_addr;
        csr_wdata = ex_csr_wdata;
        // rst gating keeps the reset-time write enable low even before the state flop settles
        csr_we    = ex_csr_we & ~trap_req & ~mret_req & ~rst;
        if (trap_req) begin
          pc_d    = trap_pc;
          cause_d = trap_cause;
          state_d = W_MEPC;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
          mret_d  = 1'b0;
`endif
        end else if (mret_req) begin
          state_d = R_MEPC;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
          mret_d  = 1'b1;
`endif
        end
      end
      W_MEPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
        csr_we    = 1'b1;
        state_d   = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        csr_we    = 1'b1;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
        state_d   = W_MSTATUS;
`else
        state_d   = R_MTVEC;
`endif
      end
      W_MSTATUS: begin
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_next;
        csr_we    = 1'b1;
        state_d   = mret_q ? REDIRECT : R_MTVEC;
`else
        state_d   = IDLE;
`endif
      end
      R_MTVEC: begin
        csr_addr      = CSR_MTVEC;
        redirect_pc_d = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
        state_d       = REDIRECT;
      end
      R_MEPC: begin
        csr_addr      = CSR_MEPC;
        redirect_pc_d = csr_rdata;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
        state_d       = W_MSTATUS;
`else
        state_d       = REDIRECT;
`endif
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      redirect_pc_q <= '0;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
      mret_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
      mret_q        <= mret_d;
`endif
    end
  end

  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22041211_trap_ctrl.sv
// Scoreboard bench for ysyx_22041211_trap_ctrl with a behavioural CSR file around it.
module tb_ysyx_22041211_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req;
  logic [31:0] trap_pc, trap_cause;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_csr_wdata;
  logic        ex_csr_we;
  logic [31:0] csr_rdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_22041211_trap_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .mret_req(mret_req),
    .trap_pc(trap_pc), .trap_cause(trap_cause),
    .ex_csr_addr(ex_csr_addr), .ex_csr_wdata(ex_csr_wdata), .ex_csr_we(ex_csr_we),
    .csr_rdata(csr_rdata), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

`ifdef YSYX_22041211_TRAP_MSTATUS_EN
  localparam int unsigned TRAP_LAT = 5;
  localparam int unsigned MRET_LAT = 3;
`else
  localparam int unsigned TRAP_LAT = 4;
  localparam int unsigned MRET_LAT = 2;
`endif

  // Environment CSR file: combinational read, write on the rising edge
  logic [31:0] m_mstatus = 32'h0000_1808;
  logic [31:0] m_mtvec   = 32'h0;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = 32'hDEAD_0000;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        is_redir;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_w(input logic [11:0] a, input logic [31:0] d, input logic [31:0] c);
    exp_t e;
    e = '{is_redir: 1'b0, addr: a, data: d, cyc: c};
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] d, input logic [31:0] c);
    exp_t e;
    e = '{is_redir: 1'b1, addr: 12'h0, data: d, cyc: c};
    exp_q.push_back(e);
  endtask

  // Monitor: every CSR write or redirect pulse must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (csr_we || redirect_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: we=%b addr=%h wdata=%h redir=%b pc=%h at cycle %0d, expected none",
                 csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        if (csr_we && (e.is_redir || csr_addr !== e.addr || csr_wdata !== e.data || cyc !== e.cyc)) begin
          fails++;
          $display("FAIL csr_write: got addr=%h data=%h cycle=%0d, expected redir=%b addr=%h data=%h cycle=%0d",
                   csr_addr, csr_wdata, cyc, e.is_redir, e.addr, e.data, e.cyc);
        end else if (!csr_we && (!e.is_redir || redirect_pc !== e.data || cyc !== e.cyc)) begin
          fails++;
          $display("FAIL redirect: got pc=%h cycle=%0d, expected redir=%b addr=%h data=%h cycle=%0d",
                   redirect_pc, cyc, e.is_redir, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic ex_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ex_csr_addr = a; ex_csr_wdata = d; ex_csr_we = 1'b1;
    push_w(a, d, cyc);
    @(posedge clk); #1;
    ex_csr_we = 1'b0;
  endtask

  // Hold the sequence for its full latency, optionally firing ex writes and new requests while busy
  task automatic run_busy(input int unsigned lat, input bit noise, input string tag);
    for (int unsigned k = 1; k <= lat; k++) begin
      ex_csr_we = noise; ex_csr_addr = 12'h7C0; ex_csr_wdata = 32'hBAD0_BAD0;
      trap_req = noise; mret_req = noise;
      @(negedge clk);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    ex_csr_we = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] redir,
                         input logic [31:0] ms_exp, input bit noise, input bit both);
    logic [31:0] base;
    @(posedge clk); #1;
    trap_req = 1'b1; trap_pc = pc; trap_cause = cause;
    mret_req = both; ex_csr_we = both; ex_csr_addr = 12'h7C1; ex_csr_wdata = 32'h1234_5678;
    base = cyc;
    push_w(12'h341, pc, base + 1);
    push_w(12'h342, cause, base + 2);
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
    push_w(12'h300, ms_exp, base + 3);
`endif
    push_r(redir, base + TRAP_LAT);
    @(negedge clk);
    check("trap_accept_busy", {31'b0, busy}, 32'd0);
    check("trap_accept_we", {31'b0, csr_we}, 32'd0);
    @(posedge clk); #1;
    trap_req = 1'b0; mret_req = 1'b0; ex_csr_we = 1'b0;
    run_busy(TRAP_LAT, noise, "trap");
  endtask

  task automatic do_mret(input logic [31:0] redir, input logic [31:0] ms_exp, input bit noise);
    logic [31:0] base;
    @(posedge clk); #1;
    mret_req = 1'b1;
    base = cyc;
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
    push_w(12'h300, ms_exp, base + 2);
`endif
    push_r(redir, base + MRET_LAT);
    @(negedge clk);
    check("mret_accept_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    mret_req = 1'b0;
    run_busy(MRET_LAT, noise, "mret");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
    trap_pc = '0; trap_cause = '0;
    ex_csr_addr = 12'h300; ex_csr_wdata = 32'h55; ex_csr_we = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_csr_we", {31'b0, csr_we}, 32'd0);
    check("rst_csr_addr", {20'b0, csr_addr}, 32'h300);
    check("rst_csr_wdata", csr_wdata, 32'h55);
    ex_csr_we = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    ex_write(12'h305, 32'h8000_0101);
    do_trap(32'h8000_0010, 32'h0000_000B, 32'h8000_0100, 32'h0000_1880, 1'b0, 1'b0);
    check("mepc_after_trap", m_mepc, 32'h8000_0010);
    check("mcause_after_trap", m_mcause, 32'h0000_000B);
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
    check("mstatus_after_trap", m_mstatus, 32'h0000_1880);
`endif
    ex_write(12'h341, 32'h8000_0014);
    do_mret(32'h8000_0014, 32'h0000_1888, 1'b0);
`ifdef YSYX_22041211_TRAP_MSTATUS_EN
    check("mstatus_after_mret", m_mstatus, 32'h0000_1888);
`endif
    do_trap(32'h8000_0030, 32'h0000_0002, 32'h8000_0100, 32'h0000_1880, 1'b1, 1'b1);
    do_mret(32'h8000_0030, 32'h0000_1888, 1'b1);
    ex_write(12'h305, 32'h0000_1003);
    do_trap(32'h0000_0044, 32'h8000_000B, 32'h0000_1000, 32'h0000_1880, 1'b1, 1'b0);

    // Reset during W_MCAUSE: only the mepc write may appear
    @(posedge clk); #1;
    trap_req = 1'b1; trap_pc = 32'h8000_0020; trap_cause = 32'h5;
    base = cyc;
    push_w(12'h341, 32'h8000_0020, base + 1);
    @(posedge clk); #1;
    trap_req = 1'b0;
    ex_csr_we = 1'b1; ex_csr_addr = 12'h7C0; ex_csr_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    check("abort_redirect_pc", redirect_pc, 32'd0);
    check("abort_csr_we", {31'b0, csr_we}, 32'd0);
    check("abort_csr_addr", {20'b0, csr_addr}, 32'h7C0);
    @(posedge clk); #1;
    rst = 1'b0; ex_csr_we = 1'b0;
    @(negedge clk);
    check("abort_next_edge_busy", {31'b0, busy}, 32'd0);
    check("abort_mcause_kept", m_mcause, 32'h8000_000B);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_trap_ctrl.md
YSYX_22041211_TRAP_CTRL -- requirements
Module: ysyx_22041211_trap_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the CSR data and PC width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port trap_req  input  1  ecall/exception request, sampled only in IDLE.
REQ-005 The block SHALL have port mret_req  input  1  mret request, sampled only in IDLE.
REQ-006 The block SHALL have port trap_pc  input  DATA_WIDTH  PC of the trapping instruction.
REQ-007 The block SHALL have port trap_cause  input  DATA_WIDTH  mcause value for the trap.
REQ-008 The block SHALL have port ex_csr_addr  input  12  CSR address from the csrr*/csrw* execute path.
REQ-009 The block SHALL have port ex_csr_wdata  input  DATA_WIDTH  CSR write data from the execute path.
REQ-010 The block SHALL have port ex_csr_we  input  1  CSR write enable from the execute path.
REQ-011 The block SHALL have port csr_rdata  input  DATA_WIDTH  combinational read data returned by the CSR file for csr_addr.
REQ-012 The block SHALL have port csr_addr  output  12  address to the CSR file.
REQ-013 The block SHALL have port csr_wdata  output  DATA_WIDTH  write data to the CSR file.
REQ-014 The block SHALL have port csr_we  output  1  write enable to the CSR file.
REQ-015 The block SHALL have port busy  output  1  high while a trap or mret sequence is in progress.
REQ-016 The block SHALL have port redirect_valid  output  1  one-cycle pulse requesting a PC redirect.
REQ-017 The block SHALL have port redirect_pc  output  DATA_WIDTH  redirect target, valid when redirect_valid is high.

Function
REQ-018 The FSM SHALL have states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MTVEC, R_MEPC and REDIRECT. W_MSTATUS is used only with the macro in REQ-031 defined.
REQ-019 CSR addresses SHALL be mstatus 0x300, mtvec 0x305, mepc 0x341 and mcause 0x342.
REQ-020 In IDLE, csr_addr, csr_wdata and csr_we SHALL mirror the ex_csr_* inputs, except that csr_we is forced 0 in any cycle where trap_req or mret_req is high.
REQ-021 In IDLE with trap_req high, the block SHALL capture trap_pc and trap_cause and go to W_MEPC. trap_req SHALL take priority over a simultaneous mret_req.
REQ-022 In IDLE with only mret_req high, the block SHALL go to R_MEPC.
REQ-023 In W_MEPC, the block SHALL drive addr 0x341, wdata = captured pc and we = 1, then go to W_MCAUSE.
REQ-024 In W_MCAUSE, the block SHALL drive addr 0x342, wdata = captured cause and we = 1, then go to W_MSTATUS if the macro is defined, otherwise to R_MTVEC.
REQ-025 In R_MTVEC, the block SHALL drive addr 0x305 with we = 0, register {csr_rdata[31:2],2'b00} into redirect_pc, then go to REDIRECT.
REQ-026 In R_MEPC, the block SHALL drive addr 0x341 with we = 0, register csr_rdata into redirect_pc, then go to W_MSTATUS if the macro is defined, otherwise to REDIRECT.
REQ-027 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle, after which the block returns to IDLE.
REQ-028 busy SHALL be 1 in every state other than IDLE. In those states, ex_csr_we, trap_req and mret_req SHALL be ignored, and the ex_csr_* inputs SHALL NOT reach the CSR port.
REQ-029 Latency with the macro undefined:
- trap accepted at cycle 0 gives redirect_valid at cycle 4;
- mret accepted at cycle 0 gives redirect_valid at cycle 2.

Reset
REQ-030 While rst is high, the FSM SHALL go immediately to IDLE and the outputs SHALL be: busy = 0, redirect_valid = 0, redirect_pc = 0, csr_we = 0, csr_addr = ex_csr_addr, csr_wdata = ex_csr_wdata. Asserting rst mid-sequence SHALL abort the sequence with no further CSR writes and no redirect pulse.

Configuration
REQ-031 With YSYX_22041211_TRAP_MSTATUS_EN defined, state W_MSTATUS SHALL drive addr 0x300 and we = 1, with wdata computed from csr_rdata as follows:
- on the trap path: MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP[12:11] <= 2'b11;
- on the mret path: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
All other bits SHALL pass through unchanged. Each sequence gains one cycle: trap redirect at cycle 5, mret redirect at cycle 3.
REQ-032 With the macro undefined, the block SHALL never write mstatus and state W_MSTATUS SHALL be unreachable.

Verification
REQ-033 The bench SHALL cover: trap_req with trap_pc 0x80000010, trap_cause 0xB and mtvec 0x80000101 -> cycle 1 writes 0x341 = 0x80000010; cycle 2 writes 0x342 = 0xB; cycle 4 redirect_valid = 1 with redirect_pc = 0x80000100; busy high cycles 1-4.
REQ-034 The bench SHALL cover: mret_req with mepc 0x80000014 -> cycle 2 redirect_valid = 1 with redirect_pc = 0x80000014, and no CSR write.
REQ-035 The bench SHALL cover: trap_req and mret_req both high, plus ex_csr_we = 1 in the same cycle -> trap sequence runs, mret is dropped, and csr_we = 0 in the accept cycle.
REQ-036 The bench SHALL cover: ex_csr_we pulses during busy, and rst asserted in W_MCAUSE -> no ex write reaches the CSR, no redirect pulse occurs, and the FSM is in IDLE with busy = 0 at the next edge.
REQ-037 The bench SHALL cover, with the macro defined: mstatus 0x1808, then trap -> mstatus = 0x1880 and redirect at cycle 5; then mret -> mstatus = 0x1888 and redirect at cycle 3.
